// File: rtl/dcm_phase_gen_pkg.sv
// Shared FSM type, status bit positions and parameter-slicing helpers
// for the DCM phase generator.
package dcm_pkg;

    typedef enum logic {StWait, StRun} dcm_state_e;

    localparam int unsigned ST_REF_LOST = 0;
    localparam int unsigned ST_PS_REJ   = 1;
    localparam int unsigned ST_PS_SAT   = 2;
    localparam int unsigned ST_LOCKED   = 3;

    // Extract field i of width w from a packed parameter vector.
    function automatic int unsigned field_of(input logic [255:0] vec, input int unsigned i,
                                             input int unsigned w);
        return 32'((vec >> (i * w)) & ((256'(1) << w) - 256'(1)));
    endfunction

    function automatic int unsigned div_of(input logic [255:0] vec, input int unsigned i,
                                           input int unsigned div_w);
        return field_of(vec, i, div_w);
    endfunction

    function automatic int unsigned phase_of(input logic [255:0] vec, input int unsigned i,
                                             input int unsigned div_w);
        return field_of(vec, i, div_w + 1);
    endfunction

endpackage

// File: rtl/dcm_phase_gen_ch.sv
// One divided clock channel: phase counter, phase register and shift apply.
// With DCM_PHASE_GEN_PS_SAT_EN defined, shifts saturate instead of wrapping.
module dcm_phase_ch #(
    parameter int unsigned CW      = 5,
    parameter int unsigned DIV     = 1,
    parameter int unsigned PH_INIT = 0
) (
    input  logic clk2x,
    input  logic resetb,
    input  logic go_run,
    input  logic stay_run,
    input  logic apply,
    input  logic inc,
    output logic clk_out,
    output logic sat
);

    localparam logic [CW-1:0] DivC   = CW'(DIV);
    localparam logic [CW-1:0] Period = CW'(2 * DIV);
    localparam logic [CW-1:0] Last   = CW'(2 * DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d, ph_q, ph_d;
    logic          clk_q, clk_d, do_shift;

    function automatic logic [CW-1:0] step(input logic [CW-1:0] v);
        return (v == Last) ? '0 : v + CW'(1);
    endfunction

`ifdef DCM_PHASE_GEN_PS_SAT_EN
    assign sat = apply && (inc ? (ph_q == Last) : (ph_q == '0));
`else
    assign sat = 1'b0;
`endif
    assign do_shift = apply & ~sat;

    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        if (go_run) begin
            // Start so that a zero-phase channel is high in the first locked cycle.
            cnt_d = (ph_q == '0) ? '0 : Period - ph_q;
        end else if (stay_run) begin
            cnt_d = step(cnt_q);
            if (do_shift) begin
                cnt_d = inc ? cnt_q : step(step(cnt_q));
                ph_d  = inc ? step(ph_q) : ((ph_q == '0) ? Last : ph_q - CW'(1));
            end
        end
        clk_d = (go_run | stay_run) && (cnt_d < DivC);
    end

    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            cnt_q <= '0;
            ph_q  <= CW'(PH_INIT);
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
            clk_q <= clk_d;
        end
    end

    assign clk_out = clk_q;

endmodule

// File: rtl/dcm_phase_gen.sv
// Multi-channel clock phase generator with lock qualification and phase-shift handshake.
// Define DCM_PHASE_GEN_PS_SAT_EN for saturating phase shifts (status[2] reports hits).
module dcm_phase_gen
    import dcm_pkg::*;
#(
    parameter int unsigned                 NUM_CH   = 4,
    parameter int unsigned                 DIV_W    = 4,
    parameter logic [NUM_CH*DIV_W-1:0]     CH_DIV   = {4'd4, 4'd2, 4'd2, 4'd1},
    parameter logic [NUM_CH*(DIV_W+1)-1:0] CH_PHASE = {5'd0, 5'd1, 5'd0, 5'd0},
    parameter int unsigned                 LOCK_DLY = 8,
    parameter int unsigned                 SEL_W    = 2
) (
    input  logic              clk2x,
    input  logic              resetb,
    input  logic              ref_locked,
    input  logic              ps_en,
    input  logic              ps_incdec,
    input  logic [SEL_W-1:0]  ps_sel,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked,
    output logic              ps_done,
    output logic [7:0]        status
);

    localparam int unsigned CW = DIV_W + 1;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be in 1..16");
    end
    if (LOCK_DLY < 1 || LOCK_DLY > 255) begin : g_bad_lock_dly
        $error("LOCK_DLY must be in 1..255");
    end
    if ((1 << SEL_W) < NUM_CH) begin : g_bad_sel_w
        $error("SEL_W too narrow for NUM_CH");
    end

    dcm_state_e        state_q, state_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              go_run, stay_run;
    logic              ps_s1_q, ps_s2_q, ps_acc_q, ps_inc_q;
    logic [SEL_W-1:0]  ps_sel_q;
    logic              ps_busy, ps_start, ps_ok, ps_apply;
    logic              lost_q, rej_q, sat_q;
    logic [NUM_CH-1:0] ch_sat;

    assign go_run   = (state_q == StWait) && ref_locked && (lock_cnt_q == 8'(LOCK_DLY - 1));
    assign stay_run = (state_q == StRun) && ref_locked;

    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            state_q    <= StWait;
            lock_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            StWait: begin
                lock_cnt_d = ref_locked ? lock_cnt_q + 8'd1 : 8'd0;
                if (go_run) begin
                    state_d    = StRun;
                    lock_cnt_d = 8'd0;
                end
            end
            StRun:   if (!ref_locked) state_d = StWait;
            default: state_d = StWait;
        endcase
    end

    always_comb begin
        locked = (state_q == StRun);
    end

    // Shift pipeline: s1 is the apply cycle, s2 the ps_done cycle; both block new requests.
    assign ps_busy  = ps_s1_q | ps_s2_q;
    assign ps_start = ps_en & ~ps_busy;
    assign ps_ok    = (state_q == StRun) && (32'(ps_sel) < NUM_CH);
    assign ps_apply = ps_s1_q & ps_acc_q & stay_run;

    always_ff @(posedge clk2x or negedge resetb) begin
        if (!resetb) begin
            ps_s1_q  <= 1'b0;
            ps_s2_q  <= 1'b0;
            ps_acc_q <= 1'b0;
            ps_inc_q <= 1'b0;
            ps_sel_q <= '0;
            lost_q   <= 1'b0;
            rej_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            ps_s1_q <= ps_start;
            ps_s2_q <= ps_s1_q;
            if (ps_start) begin
                ps_acc_q <= ps_ok;
                ps_inc_q <= ps_incdec;
                ps_sel_q <= ps_sel;
            end
            if ((state_q == StRun) && !ref_locked) lost_q <= 1'b1;
            if (ps_en && (ps_busy || !ps_ok))       rej_q  <= 1'b1;
            if (|ch_sat)                            sat_q  <= 1'b1;
        end
    end

    assign ps_done = ps_s2_q;

    always_comb begin
        status              = 8'd0;
        status[ST_REF_LOST] = lost_q;
        status[ST_PS_REJ]   = rej_q;
        status[ST_PS_SAT]   = sat_q;
        status[ST_LOCKED]   = locked;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int unsigned D = div_of(256'(CH_DIV), i, DIV_W);
        localparam int unsigned P = phase_of(256'(CH_PHASE), i, DIV_W);

        if (D == 0) begin : g_bad_div
            $error("CH_DIV entry must be non-zero");
        end
        if (P >= 2 * D) begin : g_bad_phase
            $error("CH_PHASE entry must be below twice the divide value");
        end

        dcm_phase_ch #(
            .CW     (CW),
            .DIV    (D),
            .PH_INIT(P)
        ) u_ch (
            .clk2x   (clk2x),
            .resetb  (resetb),
            .go_run  (go_run),
            .stay_run(stay_run),
            .apply   (ps_apply && (ps_sel_q == SEL_W'(i))),
            .inc     (ps_inc_q),
            .clk_out (clk_out[i]),
            .sat     (ch_sat[i])
        );
    end

endmodule
